alu_share_arb: RTL
==================

// Module: alu_share_arb
// PURPOSE
//  Shares one alu instance between two requesters (e.g. EXE-stage primary path and a
//  branch/address helper) using a round-robin arbiter and valid/ready handshakes.
//  Latches the granted operands, drives the alu, registers the result, and returns it
//  on a single response channel tagged with the requester id.
//  The alu is instantiated outside this block; it connects only through the alu_* ports.
// PARAMETERS
//  DATA_W  32  operand/result width
//  OPER_W  4   alu operation code width (EXE_ALU_* encodings from mips_define.vh)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  r0_valid    in   1       requester 0 has an operation
//  r0_ready    out  1       requester 0 operation accepted this cycle
//  r0_a,r0_b   in   DATA_W  requester 0 operands
//  r0_oper     in   OPER_W  requester 0 alu operation
//  r0_sign     in   1       requester 0 signed flag
//  r1_*        -    -       same set as r0_* for requester 1
//  rsp_valid   out  1       result available
//  rsp_ready   in   1       consumer accepts the result
//  rsp_id      out  1       requester that owns the result (0/1)
//  rsp_result  out  DATA_W  registered alu result
//  alu_a,alu_b out  DATA_W  operands driven to the alu
//  alu_oper    out  OPER_W  operation driven to the alu
//  alu_sign    out  1       signed flag driven to the alu
//  alu_result  in   DATA_W  combinational alu output
// BEHAVIOUR
//  Reset values: state=IDLE; op regs (a, b, oper, sign, id) = 0; rsp_valid=0;
//   rsp_id=0; rsp_result=0; last_grant=1, so r0 wins the first tie.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any rX_valid, grant one requester:
//    - only one valid: grant it;
//    - both valid: grant the one != last_grant.
//    rX_ready=1 only for the granted requester, only in IDLE, combinational from valid.
//    On the grant, latch a/b/oper/sign/id into op regs, set last_grant=id, go EXEC.
//   EXEC: alu sees the op regs; capture alu_result into rsp_result at the clock edge;
//    set rsp_valid=1, rsp_id=id; go RESP.
//   RESP: rsp_valid held at 1; rsp_result and rsp_id held stable until rsp_ready=1.
//    On rsp_valid & rsp_ready, clear rsp_valid and go IDLE.
//    No new grant is made in the same cycle as the response handshake.
//  r0_ready and r1_ready are 0 in EXEC and RESP. A requester must hold valid and its
//   operands stable until ready; a dropped valid before grant is not an error.
//  alu_* ports are always driven from the op regs (stable outside EXEC, 0 after reset).
//  Latency: accept at cycle N -> rsp_valid=1 at N+2. Peak throughput is 1 op per 3 cycles.
//  Width: no arithmetic in this block; the result passes through unmodified.
//  rst during EXEC or RESP: state returns to IDLE, the in-flight result is discarded,
//   rsp_valid=0, and last_grant=1.
//  rsp_ready asserted while rsp_valid=0 has no effect.
// TESTING
//  1. r0 only: a=5, b=7, oper=EXE_ALU_ADD at cycle 1 -> r0_ready@1;
//     rsp_valid@3 with id=0, result=12.
//  2. Both valid from reset: r0 SUB 10-3, r1 OR 0xF0|0x0F -> r0 served first (result 7),
//     then r1 (result 0xFF, id=1). Grants alternate while both stay valid.
//  3. Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id, rsp_result stable
//     and r0_ready=r1_ready=0 throughout; handshake -> IDLE the next cycle.
//  4. Signed flag: r1 SLT a=0xFFFFFFFF, b=1, sign=1 -> result 1;
//     same operands with sign=0 -> result 0. Confirms sign passes through to alu_sign.
//  5. Reset mid-op: assert rst in EXEC -> next cycle rsp_valid=0, state IDLE; a pending
//     r0 and r1 tie is then granted to r0.
//  6. Fairness: r0 held valid continuously with r1 pulsing -> no more than one r0 grant
//     between r1 valid and the r1 grant.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external alu between two requesters.
// Grant in IDLE, drive alu from op regs in EXEC, hold result in RESP.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int OPER_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_r0_valid,
    output logic              o_r0_ready,
    input  logic [DATA_W-1:0] i_r0_a,
    input  logic [DATA_W-1:0] i_r0_b,
    input  logic [OPER_W-1:0] i_r0_oper,
    input  logic              i_r0_sign,
    input  logic              i_r1_valid,
    output logic              o_r1_ready,
    input  logic [DATA_W-1:0] i_r1_a,
    input  logic [DATA_W-1:0] i_r1_b,
    input  logic [OPER_W-1:0] i_r1_oper,
    input  logic              i_r1_sign,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_result,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OPER_W-1:0] o_alu_oper,
    output logic              o_alu_sign,
    input  logic [DATA_W-1:0] i_alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OPER_W-1:0] r_oper;
    logic              r_sign;
    logic              r_id;
    logic              r_last;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              w_g0;
    logic              w_g1;
    logic              w_accept;

    // On a tie, the requester that was not served last wins.
    assign w_g0 = i_r0_valid & (~i_r1_valid | r_last);
    assign w_g1 = i_r1_valid & (~i_r0_valid | ~r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_r0_ready  = 1'b0;
        o_r1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_r0_ready = w_g0;
                o_r1_ready = w_g1;
                w_accept   = w_g0 | w_g1;
                if (w_accept) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: if (i_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_oper       <= '0;
            r_sign       <= 1'b0;
            r_id         <= 1'b0;
            r_last       <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= w_g1 ? i_r1_a    : i_r0_a;
                r_b    <= w_g1 ? i_r1_b    : i_r0_b;
                r_oper <= w_g1 ? i_r1_oper : i_r0_oper;
                r_sign <= w_g1 ? i_r1_sign : i_r0_sign;
                r_id   <= w_g1;
                r_last <= w_g1;
            end
            if (r_state == EXEC) begin
                r_rsp_result <= i_alu_result;
                r_rsp_id     <= r_id;
                r_rsp_valid  <= 1'b1;
            end else if (r_state == RESP && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_alu_oper   = r_oper;
    assign o_alu_sign   = r_sign;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;

endmodule
